// File: rtl/freq_meas_ctrl.sv
// Frequency measurement controller: counts rising edges of sig_in over a
// fixed gate window of clk cycles, then converts the binary count to packed
// BCD with a serial shift-add-3 engine and latches count, digits and overflow.
module freq_meas_ctrl #(
    parameter int unsigned GATE_CYCLES = 50000000,
    parameter int unsigned MAX_COUNT   = 99999999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cont,
    input  logic        sig_in,
    output logic        busy,
    output logic        done,
    output logic [26:0] count,
    output logic [31:0] digits,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GATE    = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [26:0] GATE_LAST = 27'(GATE_CYCLES - 1);
    localparam logic [26:0] CONV_LAST = 27'd26;
    localparam logic [26:0] MAX_VAL   = 27'(MAX_COUNT);

    state_t      state;
    state_t      state_nxt;
    logic        sync1;
    logic        sync2;
    logic        hist;
    logic        rise;
    logic [26:0] timer;
    logic [26:0] edges;
    logic [26:0] edges_nxt;
    logic        ovf;
    logic        ovf_nxt;
    logic [26:0] shreg;
    logic [31:0] acc;
    logic [31:0] acc_adj;
    logic        gate_end;
    logic        conv_end;

    assign rise     = sync2 & ~hist;
    assign gate_end = (state == GATE) && (timer == GATE_LAST);
    assign conv_end = (state == CONVERT) && (timer == CONV_LAST);

    // Bring sig_in into the clk domain and keep one history bit for edge detect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value of its source, which is what builds the chain.
            sync1 <= sig_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and status outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_nxt = state;
        busy      = (state != IDLE);
        done      = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = GATE;
            GATE:    if (gate_end) state_nxt = CONVERT;
            CONVERT: if (conv_end) state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = cont ? GATE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Saturating edge count for the current gate cycle; an edge at saturation
    // only raises the sticky overflow flag.
    always_comb begin
        edges_nxt = edges;
        ovf_nxt   = ovf;
        if (state == GATE && rise) begin
            if (edges == MAX_VAL) ovf_nxt   = 1'b1;
            else                  edges_nxt = edges + 27'd1;
        end
    end

    // Add-3 correction of every BCD nibble that is 5 or more.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 8; i++) begin
            if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    // Gate timer, edge counter, BCD conversion and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer    <= '0;
            edges    <= '0;
            ovf      <= 1'b0;
            shreg    <= '0;
            acc      <= '0;
            count    <= '0;
            digits   <= '0;
            overflow <= 1'b0;
        end else begin
            // The timer restarts on every state change and serves both the
            // gate window and the 27-step conversion.
            if (state_nxt != state)                      timer <= '0;
            else if (state == GATE || state == CONVERT) timer <= timer + 27'd1;

            if (state_nxt == GATE && state != GATE) begin
                edges <= '0;
                ovf   <= 1'b0;
            end else if (state == GATE) begin
                edges <= edges_nxt;
                ovf   <= ovf_nxt;
            end

            // Load from edges_nxt so an edge in the final gate cycle is kept.
            if (gate_end) begin
                shreg <= edges_nxt;
                acc   <= '0;
            end else if (state == CONVERT) begin
                {acc, shreg} <= {acc_adj[30:0], shreg, 1'b0};
            end

            // The last shift result is captured directly into digits.
            if (conv_end) begin
                count    <= edges;
                digits   <= {acc_adj[30:0], shreg[26]};
                overflow <= ovf;
            end
        end
    end

endmodule
